fetch_debug_ctrl: RTL and testbench
===================================

Name: fetch_debug_ctrl

Overview:
- Sequences the instruction-fetch stage from a byte-oriented debug link (UART receiver).
- Loads a program into instruction memory by assembling 4 bytes per instruction word and driving the memory write strobe.
- Then runs the pipeline either continuously or one clock per step command, until the fetch stage reports the halt instruction.

Parameters:
- DATA_WIDTH, 32, instruction and address width.
- MEM_DEPTH, 64, instruction memory capacity in words.
- HALT_WORD, 32'hFFFFFFFF, instruction encoding that terminates load and signals halt.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_rx_data  in  8  received byte.
- i_rx_done  in  1  one-cycle strobe; i_rx_data valid.
- i_halt  in  1  halt signal from the fetch stage (halt instruction reached PC).
- o_loading  out  1  one-cycle instruction-memory write strobe.
- o_address  out  DATA_WIDTH  write byte address (word index × 4).
- o_instruccion  out  DATA_WIDTH  assembled instruction word.
- o_start  out  1  held high during continuous run.
- o_step  out  1  one-cycle single-step pulse.
- o_state  out  3  current FSM state code, for debug readout.
- o_error  out  1  sticky flag; load overflowed MEM_DEPTH.
- o_cycles  out  DATA_WIDTH  executed-cycle count (optional feature).

Behaviour:
- Reset, all outputs: zero; state IDLE; byte counter 0; word index 0.
- Commands: 'L' = 8'h4C, 'C' = 8'h43, 'S' = 8'h53, 'R' = 8'h52. Bytes arrive only on i_rx_done.
- State encodings:
  - IDLE = 0
  - LOAD = 1
  - WAIT_CMD = 2
  - RUN = 3
  - STEP = 4
  - DONE = 5
- IDLE:
  - 'L' → LOAD; clears word index, byte counter and o_error.
  - All other bytes are ignored.
- LOAD:
  - Bytes are received MSB first: word = {word[23:0], byte}.
  - On the 4th byte, the next cycle asserts o_loading for exactly 1 cycle. o_instruccion = full word, o_address = index × 4; then index increments and the byte counter wraps to 0.
  - If the written word == HALT_WORD → WAIT_CMD in the same cycle as the o_loading pulse.
  - If index reaches MEM_DEPTH without HALT_WORD → set o_error, go to WAIT_CMD. No write ever occurs beyond MEM_DEPTH − 1.
  - A partial word is held indefinitely; there is no timeout.
- WAIT_CMD:
  - 'C' → RUN; o_start rises on the next cycle.
  - 'S' → STEP.
  - 'L' → LOAD (reload).
  - Others are ignored.
  - If i_halt is already high, 'C'/'S' go directly to DONE with no o_start/o_step.
- RUN:
  - o_start stays 1 while in RUN.
  - When i_halt = 1 is sampled → DONE; o_start drops the following cycle.
  - Received bytes are ignored.
- STEP:
  - o_step = 1 for exactly one cycle.
  - Next state is DONE if i_halt, else WAIT_CMD.
  - Consecutive 'S' bytes therefore each produce exactly one pulse.
- DONE:
  - o_start = o_step = 0.
  - 'R' → IDLE.
  - 'L' → LOAD.
  - Others are ignored.
- Simultaneous i_rx_done and i_halt in RUN: halt wins; the byte is discarded.
- Reset mid-operation (any state): returns to IDLE within one cycle. A partially assembled word is lost and o_start/o_step deassert.
- o_loading, o_start and o_step are registered outputs and are mutually exclusive.

Optional Feature:
- Macro FETCH_DEBUG_CYCLE_COUNT_EN.
- When defined:
  - o_cycles increments by 1 on every cycle where o_start or o_step is high.
  - It clears on reset and on entry to LOAD, and saturates at all-ones.
- When undefined: o_cycles is tied to 0 and no counter register is instantiated.

Test Plan:
- Load and halt: reset, send 'L', then bytes 20 08 00 05, then FF FF FF FF → two o_loading pulses: addr 0 / data 32'h20080005, then addr 4 / data 32'hFFFFFFFF; state = WAIT_CMD, o_error = 0.
- Continuous run: after load, send 'C'; raise i_halt 10 cycles later → o_start high for 10 cycles, state DONE; with the macro, o_cycles = 10.
- Step mode: after load, send 'S' three times with i_halt = 0 → exactly three 1-cycle o_step pulses, state returns to WAIT_CMD each time; 4th 'S' with i_halt = 1 → pulse, then DONE.
- Overflow: MEM_DEPTH = 4, send 'L' plus 5 non-halt words → 4 writes (addresses 0, 4, 8, 12), o_error = 1, no 5th o_loading.
- Reset mid-load: send 'L' and 2 bytes, assert i_reset 1 cycle → state IDLE; subsequent bytes are ignored until 'L'; a following full load starts at address 0 with correct byte alignment.
- Ignored bytes and race: during RUN send 'S' in the same cycle as i_halt rises → no o_step, DONE reached, then 'R' → IDLE.

Source files
------------

// File: rtl/fetch_debug_ctrl.sv
// fetch_debug_ctrl: UART-driven program loader and run/step sequencer; FETCH_DEBUG_CYCLE_COUNT_EN enables o_cycles
module fetch_debug_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_done,
  input  logic                  i_halt,
  output logic                  o_loading,
  output logic [DATA_WIDTH-1:0] o_address,
  output logic [DATA_WIDTH-1:0] o_instruccion,
  output logic                  o_start,
  output logic                  o_step,
  output logic [2:0]            o_state,
  output logic                  o_error,
  output logic [DATA_WIDTH-1:0] o_cycles
);
  typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, WAIT_CMD = 3'd2, RUN = 3'd3, STEP = 3'd4, DONE = 3'd5} state_t;
  state_t state, next;
  logic [1:0] cnt;
  logic [DATA_WIDTH-9:0] word;
  logic [DATA_WIDTH-1:0] idx, word_full;
  logic cmd_l, cmd_c, cmd_s, cmd_r, last, enter_load;
  assign cmd_l = i_rx_done && i_rx_data == 8'h4C;
  assign cmd_c = i_rx_done && i_rx_data == 8'h43;
  assign cmd_s = i_rx_done && i_rx_data == 8'h53;
  assign cmd_r = i_rx_done && i_rx_data == 8'h52;
  assign word_full = {word, i_rx_data};
  assign last = idx == DATA_WIDTH'(MEM_DEPTH - 1);
  assign enter_load = next == LOAD && state != LOAD;
  assign o_state = state;
  always_comb begin
    next = state;
    case (state)
      IDLE:     next = cmd_l ? LOAD : IDLE;
      LOAD:     next = (i_rx_done && cnt == 2'd3 && (word_full == HALT_WORD || last)) ? WAIT_CMD : LOAD;
      WAIT_CMD: next = cmd_l ? LOAD : (cmd_c || cmd_s) ? (i_halt ? DONE : cmd_c ? RUN : STEP) : WAIT_CMD;
      RUN:      next = i_halt ? DONE : RUN;
      STEP:     next = i_halt ? DONE : WAIT_CMD;
      DONE:     next = cmd_l ? LOAD : cmd_r ? IDLE : DONE;
      default:  next = IDLE;
    endcase
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= IDLE;
      cnt <= '0;
      word <= '0;
      idx <= '0;
      o_loading <= 1'b0;
      o_address <= '0;
      o_instruccion <= '0;
      o_start <= 1'b0;
      o_step <= 1'b0;
      o_error <= 1'b0;
    end else begin
      state <= next;
      o_loading <= 1'b0;
      o_start <= next == RUN;
      o_step <= next == STEP;
      if (enter_load) begin
        idx <= '0;
        cnt <= '0;
        o_error <= 1'b0;
      end else if (state == LOAD && i_rx_done) begin
        word <= word_full[DATA_WIDTH-9:0];
        cnt <= cnt + 2'd1;
        if (cnt == 2'd3) begin
          o_loading <= 1'b1;
          o_instruccion <= word_full;
          o_address <= idx << 2;
          idx <= idx + DATA_WIDTH'(1);
          if (last && word_full != HALT_WORD) o_error <= 1'b1;
        end
      end
    end
  end
`ifdef FETCH_DEBUG_CYCLE_COUNT_EN
  logic [DATA_WIDTH-1:0] cycles;
  always_ff @(posedge i_clock) begin
    if (i_reset || enter_load) cycles <= '0;
    else if ((o_start || o_step) && !(&cycles)) cycles <= cycles + DATA_WIDTH'(1);
  end
  assign o_cycles = cycles;
`else
  assign o_cycles = '0;
`endif
endmodule

// File: tb/tb_fetch_debug_ctrl.sv
// tb_fetch_debug_ctrl: scoreboard bench for the UART program loader and run/step sequencer
module tb_fetch_debug_ctrl;
  logic clk = 0, rst = 1, rx_done = 0, halt = 0;
  logic [7:0] rx_data = 0;
  logic loading, start, step, error;
  logic [31:0] address, instr, cycles;
  logic [2:0] state;
  typedef struct {bit kind; logic [31:0] addr; logic [31:0] data;} ev_t;
  ev_t q[$];
  int pass = 0, total = 0, start_cnt = 0;

  fetch_debug_ctrl #(.DATA_WIDTH(32), .MEM_DEPTH(4), .HALT_WORD(32'hFFFFFFFF)) dut (
    .i_clock(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_done(rx_done), .i_halt(halt),
    .o_loading(loading), .o_address(address), .o_instruccion(instr), .o_start(start),
    .o_step(step), .o_state(state), .o_error(error), .o_cycles(cycles));

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic push_ld(logic [31:0] a, logic [31:0] d);
    ev_t e;
    e.kind = 0; e.addr = a; e.data = d;
    q.push_back(e);
  endtask

  task automatic push_st();
    ev_t e;
    e.kind = 1; e.addr = 0; e.data = 0;
    q.push_back(e);
  endtask

  task automatic send_byte(logic [7:0] b);
    @(posedge clk); #1 rx_data = b; rx_done = 1;
    @(posedge clk); #1 rx_done = 0;
    @(posedge clk); #1;
  endtask

  task automatic send_word(logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  always @(negedge clk) if (!rst) begin
    if (start) start_cnt++;
    if (loading || step) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_pulse actual loading=%0b step=%0b required none", loading, step);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("pulse_kind", {31'd0, step}, {31'd0, e.kind});
        chk("pulse_exclusive", {30'd0, loading, step} & {30'd0, step, loading}, 0);
        if (!e.kind) begin
          chk("load_addr", address, e.addr);
          chk("load_data", instr, e.data);
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("reset_state", {29'd0, state}, 0);
    chk("reset_flags", {28'd0, loading, start, step, error}, 0);
    chk("reset_addr_instr", address | instr, 0);
    chk("reset_cycles", cycles, 0);
    // load and halt
    send_byte(8'h4C);
    chk("load_entry_state", {29'd0, state}, 1);
    push_ld(0, 32'h20080005); push_ld(4, 32'hFFFFFFFF);
    send_word(32'h20080005); send_word(32'hFFFFFFFF);
    chk("load_done_state", {29'd0, state}, 2);
    chk("load_done_error", {31'd0, error}, 0);
    // step mode
    for (int i = 0; i < 3; i++) begin
      push_st();
      send_byte(8'h53);
      chk("step_back_wait", {29'd0, state}, 2);
    end
    push_st();
    @(posedge clk); #1 rx_data = 8'h53; rx_done = 1;
    @(posedge clk); #1 rx_done = 0; halt = 1;
    chk("step_pulse_state", {29'd0, state}, 4);
    @(posedge clk); #1;
    chk("step_halt_done", {29'd0, state}, 5);
    // halt already high: 'C' goes straight to DONE with no o_start
    send_byte(8'h4C);
    push_ld(0, 32'hFFFFFFFF);
    send_word(32'hFFFFFFFF);
    chk("reload_state", {29'd0, state}, 2);
    start_cnt = 0;
    send_byte(8'h43);
    chk("halted_c_done", {29'd0, state}, 5);
    chk("halted_c_no_start", start_cnt, 0);
    send_byte(8'h52);
    chk("r_to_idle", {29'd0, state}, 0);
    halt = 0;
    // continuous run
    send_byte(8'h4C);
    push_ld(0, 32'h00000013); push_ld(4, 32'hFFFFFFFF);
    send_word(32'h00000013); send_word(32'hFFFFFFFF);
    start_cnt = 0;
    @(posedge clk); #1 rx_data = 8'h43; rx_done = 1;
    @(posedge clk); #1 rx_done = 0;
    chk("run_state", {29'd0, state}, 3);
    repeat (9) @(posedge clk);
    #1 halt = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("run_start_cycles", start_cnt, 10);
    chk("run_done_state", {29'd0, state}, 5);
    chk("run_start_low", {31'd0, start}, 0);
`ifdef FETCH_DEBUG_CYCLE_COUNT_EN
    chk("run_cycle_count", cycles, 10);
`else
    chk("run_cycle_count", cycles, 0);
`endif
    // byte racing with halt in RUN
    send_byte(8'h4C);
    push_ld(0, 32'hFFFFFFFF);
    send_word(32'hFFFFFFFF);
    halt = 0;
    send_byte(8'h43);
    chk("race_run_state", {29'd0, state}, 3);
    @(posedge clk); #1 rx_data = 8'h53; rx_done = 1; halt = 1;
    @(posedge clk); #1 rx_done = 0;
    chk("race_done_state", {29'd0, state}, 5);
    send_byte(8'h52);
    chk("race_r_idle", {29'd0, state}, 0);
    halt = 0;
    // overflow with MEM_DEPTH = 4
    send_byte(8'h4C);
    for (int i = 0; i < 4; i++) push_ld(4 * i, 32'h10000000 + i);
    for (int i = 0; i < 5; i++) send_word(32'h10000000 + i);
    chk("overflow_error", {31'd0, error}, 1);
    chk("overflow_state", {29'd0, state}, 2);
    // reset mid-load
    send_byte(8'h4C);
    send_byte(8'h12); send_byte(8'h34);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("midload_reset_state", {29'd0, state}, 0);
    chk("midload_reset_error", {31'd0, error}, 0);
    send_word(32'hAABBCCDD);
    chk("ignored_in_idle", {29'd0, state}, 0);
    send_byte(8'h4C);
    push_ld(0, 32'h12345678); push_ld(4, 32'hFFFFFFFF);
    send_word(32'h12345678); send_word(32'hFFFFFFFF);
    chk("realign_state", {29'd0, state}, 2);
    repeat (3) @(posedge clk);
    #1 chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
